mult: RTL and testbench
=======================

Name: mult

Overview:
- IEEE-754 single-precision (binary32) floating-point multiplier with one registered output stage.
- Used as the multiply primitive of the FP calculator's float-to-decimal conversion path.
- Computes result = A × B and flags exponent overflow or underflow.
- Combinational datapath feeding one output register; latency is one clock.

Parameters:
- None. Format is fixed to binary32: 1 sign bit, 8 exponent bits, 23 fraction bits, bias 127.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- A  input  32  operand A, binary32
- B  input  32  operand B, binary32
- result  output  32  registered product, binary32
- overflow  output  1  registered; set when a finite product exceeds the max normal value
- underflow  output  1  registered; set when a nonzero finite product falls below the min normal value

Behaviour:
- Reset: while rst=1, asynchronously force result=32'h0000_0000, overflow=0, underflow=0.
- Latency: outputs reflect the A/B sampled at the previous rising clk edge.
  - A new operand pair is accepted every cycle; no handshake.
- Sign: A[31] XOR B[31] for all non-NaN results.
- Subnormal inputs (exp=0, frac≠0) are treated as signed zero (flush-to-zero).
- Special cases, checked in priority order:
  - Either operand NaN (exp=255, frac≠0) -> 32'h7FC0_0000; flags 0.
  - Inf × zero -> 32'h7FC0_0000; flags 0.
  - Inf × (inf or finite nonzero) -> signed infinity; flags 0.
  - Zero × finite -> signed zero; flags 0.
- Normal path:
  - Significands: 24 bits with hidden 1; full 48-bit product.
  - Exponent: Ea + Eb − 127, computed in a 10-bit signed intermediate.
  - If product bit 47 is set, shift right 1 and increment the exponent.
  - Round to nearest, ties to even, using guard, round and sticky bits.
  - If rounding carries out of the mantissa, renormalize and increment the exponent again.
- Final exponent ≥ 255 -> signed infinity (exp=255, frac=0); overflow=1.
- Final exponent ≤ 0 -> signed zero (flush, no subnormal output); underflow=1.
- overflow and underflow are never both set.
- Both flags are 0 in every case not listed above.
- X-free: every output bit is driven for every input combination.

Decomposition:
- Package fp32_pkg:
  - Struct typedef fp32_t {sign, exp[7:0], frac[22:0]}.
  - Constants: BIAS=127, QNAN=32'h7FC0_0000, POS_INF=32'h7F80_0000, NEG_INF=32'hFF80_0000.
  - Classification functions is_nan, is_inf, is_zero.
- One natural sub-module, fp32_round_norm, taking the 48-bit product and 10-bit exponent. It performs:
  - normalization
  - RNE rounding
  - overflow/underflow detection
- The top level handles classification, sign, special-case selection and the output register.

Test Plan:
- Reset asserted mid-stream with A=32'h4000_0000 -> outputs 0 immediately; one cycle after release, result follows the new inputs.
- Normal products, each checked one cycle after the operands are applied:
  - 32'h4000_0000 × 32'h3F80_0000 -> 32'h4000_0000
  - 32'h4000_0000 × 32'h4000_0000 -> 32'h4080_0000
  - 32'h40A8_0000 × 32'h4000_0000 -> 32'h4128_0000
  - 32'hBF80_0000 × 32'h4000_0000 -> 32'hC000_0000
  - 32'h4020_0000 × 32'h4060_0000 -> 32'h410C_0000
  - all with flags 0
- Special values:
  - 32'h44FC_7333 × 32'hFF80_0001 -> 32'h7FC0_0000
  - 0 × 0 -> 32'h0000_0000
  - 32'hFF80_0000 × 32'h7F80_0000 -> 32'hFF80_0000
  - 32'h7F80_0000 × 0 -> 32'h7FC0_0000
  - 32'hFF80_0000 × 32'hFF80_0000 -> 32'h7F80_0000
  - all with flags 0
- Overflow: 32'h7F00_0000 × 32'h4000_0000 -> 32'h7F80_0000, overflow=1.
- Underflow: 32'h0080_0000 × 32'h0080_0000 -> 32'h0000_0000, underflow=1.
  - Also 32'h2F7F_D6D1 × 32'hAE36_2451 -> normal negative product with flags 0, checked against a real-arithmetic model with RNE.
- Rounding: 32'h3F80_0001 × 32'h3F80_0001 -> 32'h3F80_0002 (ties-to-even/sticky check).
- Back-to-back random normal pairs, one per cycle -> each result matches a reference model with one-cycle delay.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared binary32 definitions: field layout, special encodings and
// operand classification helpers used by the multiplier datapath.
package fp32_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    localparam logic signed [9:0] BIAS    = 10'sd127;
    localparam logic [7:0]        EXP_MAX = 8'hFF;
    localparam logic [31:0]       QNAN    = 32'h7FC0_0000;
    localparam logic [31:0]       POS_INF = 32'h7F80_0000;
    localparam logic [31:0]       NEG_INF = 32'hFF80_0000;

    function automatic logic is_nan(input fp32_t x);
        return (x.exp == EXP_MAX) && (x.frac != '0);
    endfunction

    function automatic logic is_inf(input fp32_t x);
        return (x.exp == EXP_MAX) && (x.frac == '0);
    endfunction

    // Subnormals are flushed, so any zero exponent counts as zero.
    function automatic logic is_zero(input fp32_t x);
        return (x.exp == '0);
    endfunction

    function automatic logic [31:0] signed_inf(input logic sign);
        return sign ? NEG_INF : POS_INF;
    endfunction

endpackage

// File: rtl/fp32_round_norm.sv
// Normalizes a 48-bit significand product, rounds to nearest-even and
// saturates the exponent to infinity or flushes to zero when out of range.
module fp32_round_norm (
    input  logic [47:0]       prod,
    input  logic signed [9:0] exp_in,
    output logic [7:0]        exp_out,
    output logic [22:0]       frac_out,
    output logic              overflow,
    output logic              underflow
);

    logic [23:0]       mant;
    logic              guard;
    logic              round_bit;
    logic              sticky;
    logic              round_up;
    logic [24:0]       mant_rnd;
    logic signed [9:0] exp_norm;
    logic signed [9:0] exp_final;

    // A product of two [1,2) significands lies in [1,4): at most one shift.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves it holding a value (a latch).
        mant      = '0;
        guard     = 1'b0;
        round_bit = 1'b0;
        sticky    = 1'b0;
        if (prod[47]) begin
            mant      = prod[47:24];
            guard     = prod[23];
            round_bit = prod[22];
            sticky    = |prod[21:0];
        end else begin
            mant      = prod[46:23];
            guard     = prod[22];
            round_bit = prod[21];
            sticky    = |prod[20:0];
        end
    end

    assign exp_norm = exp_in + $signed({9'b0, prod[47]});

    assign round_up = guard && (round_bit || sticky || mant[0]);
    assign mant_rnd = {1'b0, mant} + {24'b0, round_up};

    // Carry-out means the mantissa rounded up to 2.0: fraction is all zeros.
    assign exp_final = exp_norm + $signed({9'b0, mant_rnd[24]});

    always_comb begin
        overflow  = 1'b0;
        underflow = 1'b0;
        exp_out   = exp_final[7:0];
        frac_out  = mant_rnd[24] ? mant_rnd[23:1] : mant_rnd[22:0];
        if (exp_final >= 10'sd255) begin
            overflow = 1'b1;
            exp_out  = 8'hFF;
            frac_out = '0;
        end else if (exp_final <= 10'sd0) begin
            underflow = 1'b1;
            exp_out   = '0;
            frac_out  = '0;
        end
    end

endmodule

// File: rtl/mult.sv
// Single-cycle binary32 multiplier: classifies operands, selects special
// results, and registers the product together with range flags.
module mult
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow
);

    fp32_t             a_f;
    fp32_t             b_f;
    logic              sign;
    logic              nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic [47:0]       prod;
    logic signed [9:0] exp_sum;
    logic [7:0]        rn_exp;
    logic [22:0]       rn_frac;
    logic              rn_ovf;
    logic              rn_unf;
    logic [31:0]       result_d;
    logic              overflow_d;
    logic              underflow_d;

    assign a_f  = fp32_t'(A);
    assign b_f  = fp32_t'(B);
    assign sign = a_f.sign ^ b_f.sign;

    assign nan_a  = is_nan(a_f);
    assign nan_b  = is_nan(b_f);
    assign inf_a  = is_inf(a_f);
    assign inf_b  = is_inf(b_f);
    assign zero_a = is_zero(a_f);
    assign zero_b = is_zero(b_f);

    assign prod    = {24'b0, 1'b1, a_f.frac} * {24'b0, 1'b1, b_f.frac};
    assign exp_sum = $signed({2'b0, a_f.exp}) + $signed({2'b0, b_f.exp}) - BIAS;

    fp32_round_norm u_round_norm (
        .prod      (prod),
        .exp_in    (exp_sum),
        .exp_out   (rn_exp),
        .frac_out  (rn_frac),
        .overflow  (rn_ovf),
        .underflow (rn_unf)
    );

    // Special cases take priority; the rounded product is used only for finite nonzero pairs.
    always_comb begin
        result_d    = '0;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (nan_a || nan_b) begin
            result_d = QNAN;
        end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
            result_d = QNAN;
        end else if (inf_a || inf_b) begin
            result_d = signed_inf(sign);
        end else if (zero_a || zero_b) begin
            result_d = {sign, 31'b0};
        end else begin
            result_d    = {sign, rn_exp, rn_frac};
            overflow_d  = rn_ovf;
            underflow_d = rn_unf;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
            result    <= result_d;
            overflow  <= overflow_d;
            underflow <= underflow_d;
        end
    end

endmodule

// File: tb/tb_mult.sv
// Directed and random checks of the binary32 multiplier against a
// double-precision reference model with explicit RNE to binary32.
module tb_mult;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;

    int total = 0;
    int bad   = 0;

    logic [33:0] exp_q[$];

    mult dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {overflow, underflow, result}. Normal operands are widened to
    // double, where the 48-bit significand product is exact, then rounded.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [7:0]  ea, eb;
        logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [10:0] dea, deb;
        real         da, db, p;
        logic [63:0] pb;
        int          fexp;
        logic [22:0] keep;
        logic [28:0] rem;
        logic [23:0] sum;
        logic        up;
        s      = a[31] ^ b[31];
        ea     = a[30:23];
        eb     = b[30:23];
        a_nan  = (ea == 8'hFF) && (a[22:0] != 0);
        b_nan  = (eb == 8'hFF) && (b[22:0] != 0);
        a_inf  = (ea == 8'hFF) && (a[22:0] == 0);
        b_inf  = (eb == 8'hFF) && (b[22:0] == 0);
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        if (a_nan || b_nan)                       return {2'b00, 32'h7FC0_0000};
        if ((a_inf && b_zero) || (a_zero && b_inf)) return {2'b00, 32'h7FC0_0000};
        if (a_inf || b_inf)                       return {2'b00, s, 8'hFF, 23'd0};
        if (a_zero || b_zero)                     return {2'b00, s, 31'd0};
        dea  = {3'b0, ea} + 11'd896;
        deb  = {3'b0, eb} + 11'd896;
        da   = $bitstoreal({a[31], dea, a[22:0], 29'd0});
        db   = $bitstoreal({b[31], deb, b[22:0], 29'd0});
        p    = da * db;
        pb   = $realtobits(p);
        fexp = int'(pb[62:52]) - 1023 + 127;
        keep = pb[51:29];
        rem  = pb[28:0];
        up   = (rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && keep[0]);
        sum  = {1'b0, keep} + {23'd0, up};
        if (sum[23]) fexp = fexp + 1;
        if (fexp >= 255) return {2'b10, s, 8'hFF, 23'd0};
        if (fexp <= 0)   return {2'b01, s, 31'd0};
        return {2'b00, s, fexp[7:0], sum[22:0]};
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b);
        A = a;
        B = b;
        exp_q.push_back(model(a, b));
    endtask

    task automatic check_out(input string tag);
        logic [33:0] expv;
        logic [33:0] obs;
        obs = {overflow, underflow, result};
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s: no expected entry queued, observed %h", tag, obs);
        end else begin
            expv = exp_q.pop_front();
            assert (obs === expv) else begin
                bad++;
                $error("FAIL %s: observed ovf/unf/result=%h expected=%h", tag, obs, expv);
            end
        end
    endtask

    task automatic check_now(input string tag, input logic [33:0] expv);
        logic [33:0] obs;
        obs = {overflow, underflow, result};
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed ovf/unf/result=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Apply one pair and compare the registered output one cycle later.
    task automatic step(input logic [31:0] a, input logic [31:0] b, input string tag);
        drive(a, b);
        @(negedge clk);
        check_out(tag);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        rst = 1'b1;
        A   = '0;
        B   = '0;
        #3;
        check_now("reset_state", 34'h0);
        @(negedge clk);
        rst = 1'b0;

        step(32'h4000_0000, 32'h3F80_0000, "two_x_one");

        // Reset mid-stream must clear outputs without waiting for a clock edge.
        drive(32'h4000_0000, 32'h4000_0000);
        #2 rst = 1'b1;
        #1 check_now("async_reset", 34'h0);
        @(posedge clk);
        #1 check_now("reset_hold", 34'h0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        step(32'h4000_0000, 32'h4000_0000, "after_reset");

        step(32'h4000_0000, 32'h3F80_0000, "norm_2x1");
        step(32'h40A8_0000, 32'h4000_0000, "norm_5.25x2");
        step(32'hBF80_0000, 32'h4000_0000, "norm_neg");
        step(32'h4020_0000, 32'h4060_0000, "norm_2.5x3.5");

        step(32'h44FC_7333, 32'hFF80_0001, "nan_operand");
        step(32'h0000_0000, 32'h0000_0000, "zero_x_zero");
        step(32'hFF80_0000, 32'h7F80_0000, "ninf_x_inf");
        step(32'h7F80_0000, 32'h0000_0000, "inf_x_zero");
        step(32'hFF80_0000, 32'hFF80_0000, "ninf_x_ninf");
        step(32'h8000_0000, 32'h4000_0000, "negzero_x_two");
        step(32'h0000_0001, 32'h4000_0000, "subnormal_flush");

        step(32'h7F00_0000, 32'h4000_0000, "overflow");
        step(32'h0080_0000, 32'h0080_0000, "underflow");
        step(32'h2F7F_D6D1, 32'hAE36_2451, "small_normal");
        step(32'h3F80_0001, 32'h3F80_0001, "rne_sticky");
        step(32'h3FFF_FFFF, 32'h3FFF_FFFF, "round_carry");

        // Explicit expectations for key cases, independent of the model.
        drive(32'h4020_0000, 32'h4060_0000);
        @(negedge clk);
        check_now("direct_8.75", {2'b00, 32'h410C_0000});
        drive(32'h7F00_0000, 32'h4000_0000);
        void'(exp_q.pop_front());
        @(negedge clk);
        check_now("direct_ovf", {2'b10, 32'h7F80_0000});
        drive(32'h0080_0000, 32'h0080_0000);
        void'(exp_q.pop_front());
        @(negedge clk);
        check_now("direct_unf", {2'b01, 32'h0000_0000});
        drive(32'h3F80_0001, 32'h3F80_0001);
        void'(exp_q.pop_front());
        @(negedge clk);
        check_now("direct_rne", {2'b00, 32'h3F80_0002});
        exp_q.delete();

        // Back-to-back random normal operands, one new pair every cycle.
        for (int i = 0; i < 60; i++) begin
            ra = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
            rb = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
            step(ra, rb, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
